tank_ctrl_gen2: RTL and testbench

//  Parametrised per-player tank controller, one update per frame_clk edge. Decodes keyboard

---
 rtl/tank_ctrl_gen2_if.sv | 8 +
 rtl/tank_ctrl_gen2.sv | 161 ++++++++++++++++
 tb/tb_tank_ctrl_gen2.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tank_ctrl_gen2_if.sv
// tank_ctrl_gen2_if: fire request/ack handshake and bullet-expiry pulse between a tank and the bullet block
interface tank_ctrl_gen2_if;
    logic fire_req;
    logic fire_ack;
    logic bullet_done;
    modport master (output fire_req, input fire_ack, input bullet_done);
    modport slave  (input fire_req, output fire_ack, output bullet_done);
endinterface

// File: rtl/tank_ctrl_gen2.sv
// tank_ctrl_gen2: per-frame tank motion, heading, hit/respawn FSM and ammo/cooldown-gated firing
module tank_ctrl_gen2 #(
    parameter int         N_KEYS      = 4,
    parameter int         FRAC_BITS   = 3,
    parameter int         POS_W       = 10,
    parameter int         SPEED       = 16,
    parameter int         ANGLE_STEPS = 45,
    parameter int         X_RESET     = 100,
    parameter int         Y_RESET     = 250,
    parameter int         TANK_SIZE   = 10,
    parameter logic [7:0] KEY_FWD     = 8'h1a,
    parameter logic [7:0] KEY_BACK    = 8'h16,
    parameter logic [7:0] KEY_CW      = 8'h04,
    parameter logic [7:0] KEY_CCW     = 8'h07,
    parameter logic [7:0] KEY_FIRE    = 8'h14,
    parameter int         MAX_AMMO    = 5,
    parameter int         COOLDOWN    = 8,
    parameter int         RESPAWN_FR  = 60
) (
    input  logic                             frame_clk,
    input  logic                             Reset_n,
    input  logic                             hit,
    input  logic [3:0]                       wall,
    input  logic [1:0]                       game_end,
    input  logic [7:0]                       sin,
    input  logic [7:0]                       cos,
    input  logic [8*N_KEYS-1:0]              keycode,
    input  logic [POS_W-1:0]                 spawn_x,
    input  logic [POS_W-1:0]                 spawn_y,
    tank_ctrl_gen2_if.master                 bus,
    output logic [POS_W-1:0]                 TankX,
    output logic [POS_W-1:0]                 TankY,
    output logic [POS_W-1:0]                 TankS,
    output logic [$clog2(ANGLE_STEPS)-1:0]   Angle,
    output logic [$clog2(MAX_AMMO+1)-1:0]    ammo,
    output logic                             alive
);
    localparam int PW = POS_W + FRAC_BITS;
    localparam int AW = $clog2(ANGLE_STEPS);
    localparam int MW = $clog2(MAX_AMMO + 1);
    localparam int CW = $clog2(COOLDOWN + 1);
    localparam int RW = $clog2(RESPAWN_FR + 1);
    localparam logic [PW-1:0] X0      = PW'(X_RESET << FRAC_BITS);
    localparam logic [PW-1:0] Y0      = PW'(Y_RESET << FRAC_BITS);
    localparam logic [AW-1:0] A_LAST  = AW'(ANGLE_STEPS - 1);
    localparam logic [MW-1:0] A_MAX   = MW'(MAX_AMMO);
    localparam logic [CW-1:0] CD_INIT = CW'(COOLDOWN);
    localparam logic [RW-1:0] R_INIT  = RW'(RESPAWN_FR);
    localparam logic [6:0]    SPD     = 7'(SPEED);

    typedef enum logic {ALIVE, DEAD} state_t;

    state_t        state_q;
    logic [PW-1:0] x_q, y_q, lx_q, ly_q;
    logic [AW-1:0] angle_q, angle_d;
    logic [MW-1:0] ammo_q, ammo_d;
    logic [CW-1:0] cd_q, cd_d;
    logic [RW-1:0] cnt_q;
    logic          req_q, fprev_q;
    logic          k_fwd, k_back, k_cw, k_ccw, k_fire, taken, can_fire;
    logic [13:0]   pcos, psin;
    logic [PW-1:0] mcos, msin, dcos, dsin, tx, ty;

    function automatic logic has_key(input logic [8*N_KEYS-1:0] kc, input logic [7:0] k);
        has_key = 1'b0;
        for (int i = 0; i < N_KEYS; i++)
            has_key |= (kc[8*i +: 8] == k) && (k != 8'h00);
    endfunction

    assign k_fwd  = has_key(keycode, KEY_FWD);
    assign k_back = has_key(keycode, KEY_BACK);
    assign k_cw   = has_key(keycode, KEY_CW);
    assign k_ccw  = has_key(keycode, KEY_CCW);
    assign k_fire = has_key(keycode, KEY_FIRE);

    // Step magnitudes are SPEED*mag/64, then signed from the sign-magnitude LUT input.
    assign pcos = {7'b0, SPD} * {7'b0, cos[6:0]};
    assign psin = {7'b0, SPD} * {7'b0, sin[6:0]};
    assign mcos = {{(PW-8){1'b0}}, pcos[13:6]};
    assign msin = {{(PW-8){1'b0}}, psin[13:6]};
    assign dcos = cos[7] ? -mcos : mcos;
    assign dsin = sin[7] ? -msin : msin;

    // Translation, heading and fire/ammo bookkeeping for the coming frame.
    always_comb begin
        tx       = |wall ? -(lx_q << 1) : (k_fwd ^ k_back) ? (k_fwd ? dcos : -dcos) : '0;
        ty       = |wall ? -(ly_q << 1) : (k_fwd ^ k_back) ? (k_fwd ? -dsin : dsin) : '0;
        angle_d  = (|wall || !(k_cw ^ k_ccw)) ? angle_q
                 : k_cw ? ((angle_q == A_LAST) ? '0 : angle_q + 1'b1)
                 : ((angle_q == '0) ? A_LAST : angle_q - 1'b1);
        taken    = req_q & bus.fire_ack;
        ammo_d   = (taken && !bus.bullet_done) ? ammo_q - 1'b1
                 : (!taken && bus.bullet_done && ammo_q != A_MAX) ? ammo_q + 1'b1 : ammo_q;
        cd_d     = taken ? CD_INIT : (cd_q != '0) ? cd_q - 1'b1 : cd_q;
        can_fire = k_fire && !fprev_q && ammo_q != '0 && cd_q == '0 && !req_q;
    end

    // Alive/dead FSM with position, heading and firing state; game_end forces the home state.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ALIVE;
            x_q     <= X0;
            y_q     <= Y0;
            lx_q    <= '0;
            ly_q    <= '0;
            angle_q <= '0;
            ammo_q  <= A_MAX;
            cd_q    <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            fprev_q <= 1'b0;
        end else begin
            fprev_q <= k_fire;
            if (|game_end) begin
                state_q <= ALIVE;
                x_q     <= X0;
                y_q     <= Y0;
                lx_q    <= '0;
                ly_q    <= '0;
                angle_q <= '0;
                ammo_q  <= A_MAX;
                cd_q    <= '0;
                cnt_q   <= '0;
                req_q   <= 1'b0;
            end else begin
                ammo_q <= ammo_d;
                cd_q   <= cd_d;
                if (state_q == DEAD) begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == RW'(1)) begin
                        state_q <= ALIVE;
                        x_q     <= {spawn_x, {FRAC_BITS{1'b0}}};
                        y_q     <= {spawn_y, {FRAC_BITS{1'b0}}};
                        angle_q <= '0;
                    end
                end else if (hit) begin
                    state_q <= DEAD;
                    cnt_q   <= R_INIT;
                    req_q   <= 1'b0;
                    lx_q    <= '0;
                    ly_q    <= '0;
                end else begin
                    x_q     <= x_q + tx;
                    y_q     <= y_q + ty;
                    lx_q    <= tx;
                    ly_q    <= ty;
                    angle_q <= angle_d;
                    req_q   <= req_q ? !bus.fire_ack : can_fire;
                end
            end
        end
    end

    assign bus.fire_req = req_q;
    assign TankX        = x_q[PW-1:FRAC_BITS];
    assign TankY        = y_q[PW-1:FRAC_BITS];
    assign TankS        = POS_W'(TANK_SIZE);
    assign Angle        = angle_q;
    assign ammo         = ammo_q;
    assign alive        = state_q == ALIVE;
endmodule

// File: tb/tb_tank_ctrl_gen2.sv
// tb_tank_ctrl_gen2: directed scenarios plus random frames checked against a frame-level tank model
module tb_tank_ctrl_gen2;
    localparam logic [7:0] FWD = 8'h1a, BACK = 8'h16, CWK = 8'h04, CCWK = 8'h07, FIRE = 8'h14;

    logic        frame_clk, Reset_n, hit;
    logic [3:0]  wall;
    logic [1:0]  game_end;
    logic [7:0]  sin, cos;
    logic [31:0] keycode;
    logic [9:0]  spawn_x, spawn_y;
    logic [9:0]  TankX, TankY, TankS;
    logic [5:0]  Angle;
    logic [2:0]  ammo;
    logic        alive;

    tank_ctrl_gen2_if bus_if();

    tank_ctrl_gen2 dut (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .hit(hit), .wall(wall), .game_end(game_end),
        .sin(sin), .cos(cos), .keycode(keycode), .spawn_x(spawn_x), .spawn_y(spawn_y),
        .bus(bus_if), .TankX(TankX), .TankY(TankY), .TankS(TankS), .Angle(Angle),
        .ammo(ammo), .alive(alive)
    );

    int vec = 0, miss = 0;
    bit chk_on = 0;

    // Frame-level model: positions held as integers modulo 2^13 in 1/8-pixel units.
    int m_x, m_y, m_lx, m_ly, m_ang, m_ammo, m_cd, m_dead;
    bit m_req, m_alive, m_prev;

    initial begin
        frame_clk = 0;
        forever #5 frame_clk = ~frame_clk;
    end

    function automatic int wrap(int v);
        return ((v % 8192) + 8192) % 8192;
    endfunction

    function automatic int dstep(logic [7:0] v);
        int m;
        m = (16 * int'(v[6:0])) / 64;
        return v[7] ? -m : m;
    endfunction

    function automatic bit m_has(logic [7:0] k);
        for (int i = 0; i < 4; i++)
            if (keycode[8*i +: 8] == k) return 1;
        return 0;
    endfunction

    task automatic m_home();
        m_x = 100 * 8; m_y = 250 * 8; m_lx = 0; m_ly = 0; m_ang = 0;
        m_ammo = 5; m_cd = 0; m_req = 0; m_alive = 1; m_dead = 0;
    endtask

    task automatic m_step();
        bit f, b, cw, ccw, rise, taken, old_req;
        int tx, ty, old_ammo, old_cd;
        f = m_has(FWD); b = m_has(BACK); cw = m_has(CWK); ccw = m_has(CCWK);
        rise = m_has(FIRE) && !m_prev;
        m_prev = m_has(FIRE);
        if (game_end != 0) begin
            m_home();
            return;
        end
        taken = m_req && bus_if.fire_ack;
        old_req = m_req; old_ammo = m_ammo; old_cd = m_cd;
        if (taken && !bus_if.bullet_done) m_ammo--;
        else if (!taken && bus_if.bullet_done && m_ammo < 5) m_ammo++;
        m_cd = taken ? 8 : (m_cd > 0 ? m_cd - 1 : 0);
        if (!m_alive) begin
            m_dead--;
            if (m_dead == 0) begin
                m_alive = 1; m_x = int'(spawn_x) * 8; m_y = int'(spawn_y) * 8; m_ang = 0;
            end
        end else if (hit) begin
            m_alive = 0; m_dead = 60; m_req = 0; m_lx = 0; m_ly = 0;
        end else begin
            if (wall != 0) begin
                tx = -2 * m_lx; ty = -2 * m_ly;
            end else begin
                tx = (f && !b) ? dstep(cos) : (b && !f) ? -dstep(cos) : 0;
                ty = (f && !b) ? -dstep(sin) : (b && !f) ? dstep(sin) : 0;
                if (cw && !ccw) m_ang = (m_ang + 1) % 45;
                else if (ccw && !cw) m_ang = (m_ang + 44) % 45;
            end
            m_x = wrap(m_x + tx); m_y = wrap(m_y + ty);
            m_lx = wrap(tx); m_ly = wrap(ty);
            m_req = old_req ? !bus_if.fire_ack : (rise && old_ammo > 0 && old_cd == 0);
        end
    endtask

    always @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_home();
            m_prev = 0;
        end else m_step();
    end

    task automatic check(string n, logic [31:0] act, logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", n, act, exp, $time);
        end
    endtask

    always @(negedge frame_clk) begin
        if (chk_on) begin
            check("TankX", TankX, m_x >> 3);
            check("TankY", TankY, m_y >> 3);
            check("TankS", TankS, 10);
            check("Angle", Angle, m_ang);
            check("ammo", ammo, m_ammo);
            check("alive", alive, m_alive);
            check("fire_req", bus_if.fire_req, m_req);
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge frame_clk);
        #1;
    endtask

    function automatic logic [7:0] pick_key();
        case ($urandom_range(0, 7))
            1: return FWD;
            2: return BACK;
            3: return CWK;
            4: return CCWK;
            5: return FIRE;
            6: return 8'($urandom);
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        Reset_n = 0; hit = 0; wall = 0; game_end = 0; sin = 0; cos = 0; keycode = 0;
        spawn_x = 10'd300; spawn_y = 10'd200;
        bus_if.fire_ack = 0; bus_if.bullet_done = 0;
        tick(2);
        Reset_n = 1;
        chk_on = 1;
        check("rst_TankX", TankX, 100);
        check("rst_TankY", TankY, 250);
        check("rst_Angle", Angle, 0);
        check("rst_ammo", ammo, 5);
        check("rst_alive", alive, 1);
        check("rst_fire_req", bus_if.fire_req, 0);

        cos = 8'h40; sin = 8'h00; keycode = 32'h0000_1a00;
        tick(4);
        check("fwd4_TankX", TankX, 108);
        check("fwd4_TankY", TankY, 250);

        keycode = 32'h0000_0004;
        tick(44);
        check("cw44_Angle", Angle, 44);
        tick(1);
        check("cw45_wrap", Angle, 0);
        keycode = 32'h0000_0007;
        tick(1);
        check("ccw_wrap", Angle, 44);
        keycode = 32'h0000_0004;
        tick(1);
        keycode = 0;

        keycode = 32'h0000_001a;
        tick(1);
        check("pre_wall_TankX", TankX, 110);
        keycode = 32'h0000_041a; wall = 4'b0010;
        tick(1);
        check("bounce_TankX", TankX, 106);
        check("wall_Angle", Angle, 0);
        keycode = 0; wall = 0;
        tick(1);
        check("post_wall_TankX", TankX, 106);

        keycode = 32'h1400_0000;
        tick(1);
        check("shot1_req", bus_if.fire_req, 1);
        tick(1);
        check("shot1_req_held", bus_if.fire_req, 1);
        bus_if.fire_ack = 1;
        tick(1);
        bus_if.fire_ack = 0;
        check("shot1_req_drop", bus_if.fire_req, 0);
        check("shot1_ammo", ammo, 4);
        tick(17);
        check("held_no_refire", bus_if.fire_req, 0);
        check("held_ammo", ammo, 4);
        keycode = 0;
        tick(1);

        keycode = 32'h1400_0000;
        tick(1);
        check("shot2_req", bus_if.fire_req, 1);
        bus_if.fire_ack = 1;
        tick(1);
        bus_if.fire_ack = 0;
        check("shot2_ammo", ammo, 3);
        keycode = 0;
        tick(1);
        keycode = 32'h1400_0000;
        tick(1);
        check("cooldown_block", bus_if.fire_req, 0);
        keycode = 0;
        tick(10);
        for (int s = 0; s < 3; s++) begin
            keycode = 32'h1400_0000;
            tick(1);
            check("shotN_req", bus_if.fire_req, 1);
            bus_if.fire_ack = 1;
            tick(1);
            bus_if.fire_ack = 0;
            keycode = 0;
            tick(10);
        end
        check("empty_ammo", ammo, 0);
        keycode = 32'h1400_0000;
        tick(2);
        check("empty_no_req", bus_if.fire_req, 0);
        keycode = 0;
        tick(1);

        hit = 1;
        tick(1);
        hit = 0;
        check("hit_alive", alive, 0);
        keycode = 32'h0000_041a;
        tick(58);
        check("dead_alive", alive, 0);
        check("dead_TankX", TankX, 106);
        check("dead_Angle", Angle, 0);
        keycode = 0;
        tick(1);
        check("dead_last_frame", alive, 0);
        tick(1);
        check("respawn_alive", alive, 1);
        check("respawn_TankX", TankX, 300);
        check("respawn_TankY", TankY, 200);
        check("respawn_Angle", Angle, 0);

        bus_if.bullet_done = 1;
        tick(3);
        bus_if.bullet_done = 0;
        check("refill_ammo", ammo, 3);
        keycode = 32'h1400_0000;
        tick(1);
        check("pre_rst_req", bus_if.fire_req, 1);
        #2 Reset_n = 0;
        #1;
        check("async_rst_req", bus_if.fire_req, 0);
        check("async_rst_ammo", ammo, 5);
        check("async_rst_TankX", TankX, 100);
        keycode = 0;
        tick(1);
        Reset_n = 1;
        hit = 1;
        tick(1);
        hit = 0;
        tick(5);
        check("pre_rst_dead", alive, 0);
        #2 Reset_n = 0;
        #1;
        check("async_rst_alive", alive, 1);
        check("async_rst_TankY", TankY, 250);
        tick(1);
        Reset_n = 1;

        keycode = 32'h0000_001a;
        tick(2);
        check("pre_end_TankX", TankX, 104);
        game_end = 2'b10;
        tick(2);
        check("game_end_TankX", TankX, 100);
        check("game_end_alive", alive, 1);
        game_end = 0; keycode = 0;
        tick(1);

        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) keycode[8*i +: 8] = pick_key();
            sin = 8'($urandom);
            cos = 8'($urandom);
            wall = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
            hit = $urandom_range(0, 99) == 0;
            game_end = ($urandom_range(0, 399) == 0) ? 2'($urandom_range(1, 3)) : 2'b0;
            bus_if.fire_ack = $urandom_range(0, 2) == 0;
            bus_if.bullet_done = $urandom_range(0, 9) == 0;
            spawn_x = 10'($urandom);
            spawn_y = 10'($urandom);
            tick(1);
        end

        chk_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
